// File: rtl/noc_input_buffer_if.sv
// noc_input_buffer_if: handshake/bus bundle between a NoC input buffer and
// its neighbours (link writer on one side, arbiter on the other).
// Optional macro DROP_CNT_EN adds the 8-bit drop_cnt observation signal.
interface noc_input_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  grant;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  req;
    logic [2:0]            flit_id;
    logic [11:0]           length;
    logic [DATA_WIDTH-1:0] dout;
    logic                  pop;
`ifdef DROP_CNT_EN
    logic [7:0]            drop_cnt;

    modport master (
        output wr_en, din, grant,
        input  full, empty, count, req, flit_id, length, dout, pop, drop_cnt
    );
    modport slave (
        input  wr_en, din, grant,
        output full, empty, count, req, flit_id, length, dout, pop, drop_cnt
    );
`else
    modport master (
        output wr_en, din, grant,
        input  full, empty, count, req, flit_id, length, dout, pop
    );
    modport slave (
        input  wr_en, din, grant,
        output full, empty, count, req, flit_id, length, dout, pop
    );
`endif
endinterface

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port input FIFO and packet framer for the 5-port NoC
// router. Show-ahead circular buffer; a small FSM (IDLE/HEAD/XFER) frames
// packets at the FIFO head and presents req/flit_id/length to the arbiter.
// Optional macro DROP_CNT_EN adds a saturating 8-bit count of lost flits
// (writes refused while full and orphan flits discarded in IDLE).
module noc_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic               clk,
    input logic               rst,
    noc_input_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] ID_HDR  = 3'b001;
    localparam logic [2:0] ID_TAIL = 3'b100;

    typedef enum logic [1:0] {IDLE, HEAD, XFER} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [11:0]           length_q;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  req;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            head_id;
    logic                  head_is_hdr;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign push        = bus.wr_en && (!full || pop);
    assign head        = empty ? '0 : mem[rd_ptr];
    assign head_id     = head[DATA_WIDTH-1:DATA_WIDTH-3];
    assign head_is_hdr = !empty && (head_id == ID_HDR);

    // Request/pop decode from registered state and the FIFO head.
    always_comb begin
        req = 1'b0;
        pop = 1'b0;
        case (state)
            IDLE: pop = !empty && !head_is_hdr;
            HEAD: begin
                req = 1'b1;
                pop = bus.grant && !empty;
            end
            XFER: begin
                // A header here means the tail went missing: hold it and
                // let the FSM re-enter HEAD with req low for this cycle.
                if (!head_is_hdr) begin
                    req = 1'b1;
                    pop = bus.grant && !empty;
                end
            end
            default: ;
        endcase
    end

    // Packet framing FSM; also latches the packet length when the header leaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            length_q <= '0;
        end else begin
            case (state)
                IDLE: if (head_is_hdr) state <= HEAD;
                HEAD: begin
                    if (pop) begin
                        length_q <= head[11:0];
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (head_is_hdr)
                        state <= HEAD;
                    else if (pop && head_id == ID_TAIL)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Flit storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.din;
    end

`ifdef DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       drop_evt;

    assign drop_evt = (bus.wr_en && full && !pop) || (state == IDLE && pop);

    // Saturating count of flits lost to overflow or orphan discard.
    always_ff @(posedge clk) begin
        if (!rst)
            drop_cnt <= '0;
        else if (drop_evt && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

    assign bus.drop_cnt = drop_cnt;
`endif

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.count   = count;
    assign bus.req     = req;
    assign bus.pop     = pop;
    assign bus.dout    = head;
    assign bus.flit_id = head_id;
    // While a header waits in HEAD the arbiter sees its length directly.
    assign bus.length  = (state == HEAD) ? head[11:0] : length_q;
endmodule
